max_sub_cam_buffer: RTL and testbench

- Parametrised successor of the softmax max-subtract stage.
- Captures a vector of N_ELEM signed samples through a valid/ready handshake and tracks the running maximum.
- Then streams each (x_i − max), clamped to the LUT window, together with its one-hot match vector for the downstream exp LUT.
- Sits between the data fetch front-end and the CAM/LUT exp stage of STAR.

---
 rtl/max_sub_cam_buffer.sv | 115 +++++++++++
 tb/tb_max_sub_cam_buffer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/max_sub_cam_buffer.sv
// rtl/max_sub_cam_buffer.sv - captures a sample vector, tracks its max, streams clamped (x - max) with one-hot match vector
module max_sub_cam_buffer #(
  parameter int DATA_W    = 8,
  parameter int N_ELEM    = 16,
  parameter int MV_W      = 64,
  parameter int MV_OFFSET = 50,
  localparam int IDX_W    = (N_ELEM > 1) ? $clog2(N_ELEM) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W:0]   out_sub,
  output logic [MV_W-1:0]          out_mv,
  output logic [IDX_W-1:0]         out_idx,
  output logic                     out_last,
  output logic                     out_clamped,
  output logic signed [DATA_W-1:0] max_val
);

  localparam logic [0:0] FILL  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(N_ELEM - 1);
  localparam logic signed [DATA_W:0] NEG_OFF = (DATA_W + 1)'(-MV_OFFSET);

  logic [0:0]               state;
  logic [IDX_W-1:0]         wr_cnt;
  logic [IDX_W-1:0]         rd_cnt;
  logic signed [DATA_W-1:0] sample_buf [N_ELEM];

  logic                     in_fire;
  logic                     load;
  logic                     finish;
  logic signed [DATA_W:0]   rd_x;
  logic signed [DATA_W:0]   max_x;
  logic signed [DATA_W:0]   diff;
  logic                     clamp;
  logic signed [DATA_W:0]   sub;
  logic [DATA_W:0]          pos;
  logic [MV_W-1:0]          mv;

  assign in_ready = (state == FILL);
  assign in_fire  = in_valid & in_ready;

  // The final beat is not reloaded; its handshake ends the vector instead.
  assign finish = (state == DRAIN) && out_valid && out_ready && out_last;
  assign load   = (state == DRAIN) && (!out_valid || out_ready) && !(out_valid && out_last);

  assign rd_x  = {sample_buf[rd_cnt][DATA_W-1], sample_buf[rd_cnt]};
  assign max_x = {max_val[DATA_W-1], max_val};
  assign diff  = rd_x - max_x;
  assign clamp = diff < NEG_OFF;
  assign sub   = clamp ? NEG_OFF : diff;
  assign pos   = $unsigned(sub - NEG_OFF);
  assign mv    = MV_W'(1) << pos;

  always_ff @(posedge clk) begin
    if (in_fire && !clear) begin
      sample_buf[wr_cnt] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= FILL;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      out_valid   <= 1'b0;
      out_sub     <= '0;
      out_mv      <= '0;
      out_idx     <= '0;
      out_last    <= 1'b0;
      out_clamped <= 1'b0;
      max_val     <= '0;
    end else if (clear) begin
      state     <= FILL;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      out_valid <= 1'b0;
    end else if (state == FILL) begin
      if (in_fire) begin
        // First sample seeds the max so stale values never leak in.
        if (wr_cnt == '0 || in_data > max_val) begin
          max_val <= in_data;
        end
        if (wr_cnt == LAST_IDX) begin
          wr_cnt <= '0;
          state  <= DRAIN;
        end else begin
          wr_cnt <= wr_cnt + IDX_W'(1);
        end
      end
    end else begin
      if (finish) begin
        out_valid <= 1'b0;
        rd_cnt    <= '0;
        state     <= FILL;
      end else if (load) begin
        out_valid   <= 1'b1;
        out_sub     <= sub;
        out_mv      <= mv;
        out_idx     <= rd_cnt;
        out_last    <= (rd_cnt == LAST_IDX);
        out_clamped <= clamp;
        rd_cnt      <= (rd_cnt == LAST_IDX) ? '0 : rd_cnt + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_max_sub_cam_buffer.sv
// tb/tb_max_sub_cam_buffer.sv - scoreboard bench for max_sub_cam_buffer
module tb_max_sub_cam_buffer;

  localparam int DATA_W = 8;
  localparam int N_ELEM = 4;
  localparam int MV_W   = 64;
  localparam int MV_OFF = 50;

  typedef struct {
    int sub;
    int bit_pos;
    int idx;
    bit last;
    bit clamped;
  } beat_t;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic                     clear = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b1;
  logic signed [DATA_W:0]   out_sub;
  logic [MV_W-1:0]          out_mv;
  logic [1:0]               out_idx;
  logic                     out_last;
  logic                     out_clamped;
  logic signed [DATA_W-1:0] max_val;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    rdy_mode = 0;
  int    bp_i     = 0;
  beat_t sb[$];

  max_sub_cam_buffer #(
    .DATA_W(DATA_W), .N_ELEM(N_ELEM), .MV_W(MV_W), .MV_OFFSET(MV_OFF)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sub(out_sub),
    .out_mv(out_mv), .out_idx(out_idx), .out_last(out_last),
    .out_clamped(out_clamped), .max_val(max_val)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // out_ready pattern: 0 = always ready, 1 = 1,0,0,1 toggle, 2 = never ready
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1: begin
        out_ready = (bp_i == 0 || bp_i == 3);
        bp_i = (bp_i + 1) % 4;
      end
      2: out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  logic                     prev_stall = 1'b0;
  logic signed [DATA_W:0]   prev_sub;
  logic [MV_W-1:0]          prev_mv;
  logic [1:0]               prev_idx;
  logic                     prev_last;

  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (out_valid) begin
        check_eq("in_ready_in_drain", in_ready, 0);
      end
      if (prev_stall) begin
        check_eq("hold_valid", out_valid, 1);
        check_eq("hold_sub", longint'(out_sub), longint'(prev_sub));
        check_eq("hold_mv", longint'(out_mv), longint'(prev_mv));
        check_eq("hold_idx", out_idx, prev_idx);
        check_eq("hold_last", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_beat", 1, 0);
        end else begin
          beat_t e;
          e = sb.pop_front();
          check_eq("sub", longint'(out_sub), e.sub);
          check_eq("mv", longint'(out_mv), longint'(64'd1 << e.bit_pos));
          check_eq("idx", out_idx, e.idx);
          check_eq("last", out_last, e.last);
          check_eq("clamped", out_clamped, e.clamped);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_sub   = out_sub;
      prev_mv    = out_mv;
      prev_idx   = out_idx;
      prev_last  = out_last;
    end
  end

  task automatic send_sample(input logic signed [DATA_W-1:0] d);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check_eq("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_vec(input int v[4], input bit push, input bit bubbles);
    int mx;
    if (push) begin
      mx = v[0];
      for (int i = 1; i < 4; i++) if (v[i] > mx) mx = v[i];
      for (int i = 0; i < 4; i++) begin
        beat_t e;
        int d;
        d = v[i] - mx;
        e.clamped = (d < -MV_OFF);
        e.sub     = e.clamped ? -MV_OFF : d;
        e.bit_pos = e.sub + MV_OFF;
        e.idx     = i;
        e.last    = (i == 3);
        sb.push_back(e);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (bubbles) begin
        repeat ($urandom_range(0, 2)) begin
          in_data = DATA_W'($urandom);
          @(posedge clk);
          #1;
        end
      end
      send_sample(DATA_W'(v[i]));
    end
  endtask

  task automatic wait_empty();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check_eq("drain_done", sb.size(), 0);
    @(posedge clk);
    #1;
    check_eq("in_ready_back", in_ready, 1);
  endtask

  initial begin
    int t;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_max_val", max_val, 0);
    check_eq("rst_out_mv", longint'(out_mv), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_in_ready", in_ready, 1);

    // basic vector plus first-beat latency
    send_vec('{3, -2, 7, 7}, 1'b1, 1'b0);
    check_eq("lat_not_yet", out_valid, 0);
    check_eq("max_basic", max_val, 7);
    @(posedge clk);
    #1;
    check_eq("lat_one", out_valid, 1);
    wait_empty();

    send_vec('{-20, -5, -30, -8}, 1'b1, 1'b0);
    check_eq("max_neg", max_val, -5);
    wait_empty();

    send_vec('{127, -128, 0, 100}, 1'b1, 1'b0);
    check_eq("max_clamp", max_val, 127);
    wait_empty();

    rdy_mode = 1;
    send_vec('{10, -3, 5, 2}, 1'b1, 1'b0);
    wait_empty();
    rdy_mode = 0;

    // bubbles in FILL, in_valid held with junk data through DRAIN
    send_vec('{3, -2, 7, 7}, 1'b1, 1'b1);
    in_valid = 1'b1;
    in_data  = -8'sd100;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    in_valid = 1'b0;
    check_eq("bubble_drain", sb.size(), 0);
    @(posedge clk);
    #1;
    check_eq("bubble_in_ready", in_ready, 1);

    // clear after two accepts; the simultaneous sample is dropped
    send_sample(8'sd50);
    send_sample(8'sd60);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'sd99;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    check_eq("clear_in_ready", in_ready, 1);
    check_eq("clear_out_valid", out_valid, 0);
    send_vec('{1, 2, 3, 4}, 1'b1, 1'b0);
    check_eq("max_after_clear", max_val, 4);
    wait_empty();

    // reset mid-DRAIN with the sink stalled
    rdy_mode = 2;
    @(posedge clk);
    #1;
    send_vec('{9, 8, 7, 6}, 1'b0, 1'b0);
    t = 0;
    while (!out_valid && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    check_eq("pre_reset_valid", out_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_out_sub", longint'(out_sub), 0);
    check_eq("mid_rst_out_mv", longint'(out_mv), 0);
    check_eq("mid_rst_out_idx", out_idx, 0);
    check_eq("mid_rst_max", max_val, 0);
    check_eq("mid_rst_in_ready", in_ready, 1);
    rdy_mode = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    send_vec('{1, 2, 3, 4}, 1'b1, 1'b0);
    wait_empty();

    check_eq("sb_empty_end", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
